imem_loader: RTL and testbench

Program loader that writes instruction words into the instruction memory read by the fetch stage.
- Accepts a byte stream over a valid/ready handshake.
- Assembles bytes big-endian into 32-bit instruction words and writes them to sequential addresses from 0.
- Holds the CPU pipeline until a halt instruction (opcode [31:26] = 6'b111111) has been written.
- It is the writer side of the instruction memory that fetch reads, and it gates pipeline start.

---
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes MSB-first into 32-bit words and writes imem from address 0.
// Latency: the word write comes 1 cycle after its 4th byte; in_ready drops only in the write cycle and after the load ends.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [31:0]       asm_word, asm_word_n;
  logic              in_ready_n, imem_we_n, cpu_hold_n, done_n, error_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [31:0]       imem_wdata_n;
  logic [ADDR_W:0]   word_count_n;
  logic [31:0]       shifted_word;
  logic              accept;
  logic              begin_load;

  assign shifted_word = {asm_word[23:0], in_data};
  assign accept       = in_valid && in_ready;
  assign begin_load   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // Every output is computed here one cycle ahead and then registered.
  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    asm_word_n   = asm_word;
    in_ready_n   = 1'b0;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    cpu_hold_n   = cpu_hold;
    done_n       = done;
    error_n      = error;
    word_count_n = word_count;

    if (begin_load) begin
      state_n      = S_RECV;
      byte_cnt_n   = 2'd0;
      in_ready_n   = 1'b1;
      imem_addr_n  = '0;
      word_count_n = '0;
      cpu_hold_n   = 1'b1;
      done_n       = 1'b0;
      error_n      = 1'b0;
    end else begin
      case (state)
        S_RECV: begin
          in_ready_n = 1'b1;
          if (accept) begin
            asm_word_n = shifted_word;
            byte_cnt_n = byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state_n      = S_WRITE;
              in_ready_n   = 1'b0;
              imem_we_n    = 1'b1;
              imem_wdata_n = shifted_word;
              word_count_n = word_count + {{ADDR_W{1'b0}}, 1'b1};
            end
          end
        end
        S_WRITE: begin
          // The word just written is still on imem_wdata and decides the exit.
          if (imem_wdata[31:26] == 6'b111111) begin
            state_n    = S_DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else if (imem_addr == {ADDR_W{1'b1}}) begin
            state_n = S_ERR;
            error_n = 1'b1;
          end else begin
            state_n     = S_RECV;
            in_ready_n  = 1'b1;
            imem_addr_n = imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_IDLE;
      byte_cnt   <= 2'd0;
      asm_word   <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      asm_word   <= asm_word_n;
      in_ready   <= in_ready_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      cpu_hold   <= cpu_hold_n;
      done       <= done_n;
      error      <= error_n;
      word_count <= word_count_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size loader plus a 4-word copy sharing the same stimulus.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        clr, start, in_valid;
  logic [7:0]  in_data;

  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        s_in_ready, s_imem_we, s_cpu_hold, s_done, s_error;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_word_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_addr[$], q_data[$], s_addr[$], s_data[$];
  int acc_cnt = 0, mid_bad = 0, we_rdy = 0, rdy_low = 0;
  bit track = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  imem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .cpu_hold(s_cpu_hold), .done(s_done), .error(s_error), .word_count(s_word_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      q_addr.push_back(32'(imem_addr));
      q_data.push_back(imem_wdata);
      if (acc_cnt != 4) mid_bad++;
      if (in_ready) we_rdy++;
      acc_cnt = 0;
    end
    if (s_imem_we) begin
      s_addr.push_back(32'(s_imem_addr));
      s_data.push_back(s_imem_wdata);
    end
    if (in_valid && in_ready) acc_cnt++;
    if (track && !done && !in_ready) rdy_low++;
  end

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < q_data.size()) begin
      chk({tag, "_addr"}, q_addr[idx], a);
      chk({tag, "_data"}, q_data[idx], d);
    end else begin
      chk({tag, "_missing"}, 32'(q_data.size()), 32'(idx + 1));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) send_byte(t[31-8*k -: 8], gap);
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    if (!got) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); s_addr.delete(); s_data.delete();
  endtask

  initial begin
    bit got;
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done_err", {30'd0, done, error}, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    clr = 1'b0;

    // basic load, full rate
    clear_q();
    pulse_start();
    chk("start_ready", 32'(in_ready), 32'd1);
    send_word(32'h20010005, 0);
    send_word(32'h00221820, 0);
    send_word(32'hFC000000, 0);
    wait_done("basic");
    chk("basic_nwr", 32'(q_data.size()), 32'd3);
    check_wr("basic_w0", 0, 32'd0, 32'h20010005);
    check_wr("basic_w1", 1, 32'd1, 32'h00221820);
    check_wr("basic_w2", 2, 32'd2, 32'hFC000000);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_hold", 32'(cpu_hold), 32'd0);
    chk("basic_wc", 32'(word_count), 32'd3);
    chk("basic_ready", 32'(in_ready), 32'd0);

    // backpressure with 3-cycle gaps; also a reload from DONE
    clear_q();
    pulse_start();
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_wc", 32'(word_count), 32'd0);
    acc_cnt = 0; mid_bad = 0; we_rdy = 0; rdy_low = 0; track = 1;
    send_word(32'h20010005, 3);
    send_word(32'h00221820, 3);
    send_word(32'hFC000000, 3);
    wait_done("bp");
    track = 0;
    chk("bp_nwr", 32'(q_data.size()), 32'd3);
    check_wr("bp_w0", 0, 32'd0, 32'h20010005);
    check_wr("bp_w1", 1, 32'd1, 32'h00221820);
    check_wr("bp_w2", 2, 32'd2, 32'hFC000000);
    chk("bp_mid_word_we", 32'(mid_bad), 32'd0);
    chk("bp_we_with_ready", 32'(we_rdy), 32'd0);
    chk("bp_ready_low_cycles", 32'(rdy_low), 32'd3);
    chk("bp_wc", 32'(word_count), 32'd3);

    // reset in the middle of word 1
    pulse_start();
    send_word(32'h20010005, 0);
    send_byte(8'h00, 0);
    send_byte(8'h22, 0);
    chk("mid_wc_before", 32'(word_count), 32'd1);
    clr = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    @(posedge clk); #1 clr = 1'b0;
    clear_q();
    pulse_start();
    send_word(32'hABCDEF01, 0);
    send_word(32'hFC000000, 0);
    wait_done("mid");
    check_wr("mid_w0", 0, 32'd0, 32'hABCDEF01);
    check_wr("mid_w1", 1, 32'd1, 32'hFC000000);
    chk("mid_wc", 32'(word_count), 32'd2);

    // start during RECV and WRITE is ignored
    clear_q();
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_start();
    chk("ign_recv_ready", 32'(in_ready), 32'd1);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    chk("ign_in_write", 32'(imem_we), 32'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("ign_write_addr", 32'(imem_addr), 32'd1);
    chk("ign_write_wc", 32'(word_count), 32'd1);
    send_word(32'hFC000000, 0);
    wait_done("ign");
    check_wr("ign_w0", 0, 32'd0, 32'h12345678);
    check_wr("ign_w1", 1, 32'd1, 32'hFC000000);
    chk("ign_wc", 32'(word_count), 32'd2);

    // 1-word halt reload
    clear_q();
    pulse_start();
    chk("halt1_hold", 32'(cpu_hold), 32'd1);
    chk("halt1_done0", 32'(done), 32'd0);
    send_word(32'hFC000000, 0);
    wait_done("halt1");
    check_wr("halt1_w0", 0, 32'd0, 32'hFC000000);
    chk("halt1_wc", 32'(word_count), 32'd1);
    chk("halt1_hold_rel", 32'(cpu_hold), 32'd0);

    // overflow on the 4-word instance
    clear_q();
    pulse_start();
    for (int w = 0; w < 4; w++) send_word(32'h00000000, 0);
    got = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (s_error) begin got = 1; break; end
    end
    if (!got) chk("ovf_err_timeout", 32'd0, 32'd1);
    chk("ovf_nwr", 32'(s_data.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < s_addr.size()) chk("ovf_addr", s_addr[i], 32'(i));
    chk("ovf_error", 32'(s_error), 32'd1);
    chk("ovf_hold", 32'(s_cpu_hold), 32'd1);
    chk("ovf_done", 32'(s_done), 32'd0);
    chk("ovf_wc", 32'(s_word_count), 32'd4);
    chk("ovf_ready", 32'(s_in_ready), 32'd0);
    s_addr.delete(); s_data.delete();
    pulse_start();
    chk("ovf_restart_err", 32'(s_error), 32'd0);
    chk("ovf_restart_addr", 32'(s_imem_addr), 32'd0);
    send_word(32'hFC000000, 0);
    wait_done("ovf_restart");
    chk("ovf_restart_nwr", 32'(s_data.size()), 32'd1);
    if (s_addr.size() > 0) chk("ovf_restart_w0", s_addr[0], 32'd0);
    chk("ovf_restart_done", 32'(s_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
